// File: rtl/spi_flash_writer.sv
// ----------------------------------------------------------------------------
// spi_flash_writer
//
// Runs one write-type operation on a SPI NOR flash. Each operation is either a
// single-byte page program (0x02) or a 4 KB sector erase (0x20). The full
// sequence is:
//
//   WREN (0x06) -> gap -> PROGRAM/ERASE -> gap -> READ STATUS (0x05)
//   -> (gap -> READ STATUS)* while WIP=1 -> done
//
// The SPI link is mode 0. Each bit takes two clk cycles. In the low phase,
// sck=0 and mosi carries the bit. In the high phase, sck=1. miso is sampled
// on the clk edge that ends the high phase.
//
// Parameters
//   CS_GAP     clk cycles that cs_n is held high between frames (>= 2)
//   MAX_POLLS  status reads allowed before the operation is flagged timed-out
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   cmd_valid  request strobe, only looked at while idle
//   cmd_erase  1 = sector erase, 0 = single-byte page program
//   addr       24-bit flash byte address
//   wdata      byte to program (unused for erase)
//   busy       operation in progress
//   done       one-cycle completion pulse
//   err        timeout flag of the last operation, held until next acceptance
//   status     last status register byte read from the flash
//   sck        SPI clock (idles low)
//   cs_n       SPI chip select, active low
//   mosi       SPI data to the flash
//   miso       SPI data from the flash
// ----------------------------------------------------------------------------
module spi_flash_writer #(
    parameter int unsigned CS_GAP    = 4,
    parameter int unsigned MAX_POLLS = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        cmd_erase,
    input  logic [23:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  status,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam int unsigned GAP_W  = $clog2(CS_GAP);
    localparam int unsigned POLL_W = ($clog2(MAX_POLLS + 1) > 20) ? $clog2(MAX_POLLS + 1) : 20;

    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(CS_GAP - 1);
    localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(MAX_POLLS);

    localparam logic [7:0] OPC_WREN  = 8'h06;
    localparam logic [7:0] OPC_PP    = 8'h02;
    localparam logic [7:0] OPC_SE    = 8'h20;
    localparam logic [7:0] OPC_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        IDLE,
        WREN,
        GAP1,
        OP,
        GAP2,
        POLL,
        GAP3,
        FIN
    } state_t;

    state_t              state_q,   state_d;
    logic [39:0]         shift_q,   shift_d;
    logic [5:0]          bitCnt_q,  bitCnt_d;
    logic                phase_q,   phase_d;
    logic [GAP_W-1:0]    gapCnt_q,  gapCnt_d;
    logic [POLL_W-1:0]   pollCnt_q, pollCnt_d;
    logic [6:0]          rxShift_q, rxShift_d;
    logic [7:0]          status_q,  status_d;
    logic                err_q,     err_d;
    logic                erase_q,   erase_d;
    logic [23:0]         addr_q,    addr_d;
    logic [7:0]          wdata_q,   wdata_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                csN_q,     csN_d;
    logic                sck_q,     sck_d;
    logic                mosi_q,    mosi_d;

    logic [POLL_W-1:0]   pollNext;
    logic                inFrame;

    assign pollNext = pollCnt_q + 1'b1;

    // State register. Every output is a flop, so the SPI pins and the
    // handshake outputs cannot glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            phase_q   <= 1'b0;
            gapCnt_q  <= '0;
            pollCnt_q <= '0;
            rxShift_q <= '0;
            status_q  <= '0;
            err_q     <= 1'b0;
            erase_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            csN_q     <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitCnt_q  <= bitCnt_d;
            phase_q   <= phase_d;
            gapCnt_q  <= gapCnt_d;
            pollCnt_q <= pollCnt_d;
            rxShift_q <= rxShift_d;
            status_q  <= status_d;
            err_q     <= err_d;
            erase_q   <= erase_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            csN_q     <= csN_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
        end
    end

    // Next-state logic. A frame is loaded left-justified into shift_q, and
    // bitCnt_q counts the bits still to send after the current one. The pins
    // are derived from the next-state values, so cs_n falls on the same edge
    // that presents the first bit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitCnt_d  = bitCnt_q;
        phase_d   = phase_q;
        gapCnt_d  = gapCnt_q;
        pollCnt_d = pollCnt_q;
        rxShift_d = rxShift_q;
        status_d  = status_q;
        err_d     = err_q;
        erase_d   = erase_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    erase_d   = cmd_erase;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    pollCnt_d = '0;
                    err_d     = 1'b0;
                    shift_d   = {OPC_WREN, 32'h0};
                    bitCnt_d  = 6'd7;
                    phase_d   = 1'b0;
                    state_d   = WREN;
                end
            end

            WREN, OP, POLL: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (state_q == POLL) begin
                        rxShift_d = {rxShift_q[5:0], miso};
                    end
                    if (bitCnt_q != 6'd0) begin
                        shift_d  = {shift_q[38:0], 1'b0};
                        bitCnt_d = bitCnt_q - 6'd1;
                    end else begin
                        // The last high phase ends here, so cs_n rises on this edge.
                        shift_d  = '0;
                        gapCnt_d = GAP_LAST;
                        if (state_q == WREN) begin
                            state_d = GAP1;
                        end else if (state_q == OP) begin
                            state_d = GAP2;
                        end else begin
                            // The final miso bit is the WIP flag, status[0].
                            status_d  = {rxShift_q, miso};
                            pollCnt_d = pollNext;
                            if (!miso) begin
                                err_d   = 1'b0;
                                state_d = FIN;
                            end else if (pollNext >= POLL_LIMIT) begin
                                err_d   = 1'b1;
                                state_d = FIN;
                            end else begin
                                state_d = GAP3;
                            end
                        end
                    end
                end
            end

            GAP1, GAP2, GAP3: begin
                if (gapCnt_q != '0) begin
                    gapCnt_d = gapCnt_q - 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (state_q == GAP1) begin
                        if (erase_q) begin
                            shift_d  = {OPC_SE, addr_q, 8'h00};
                            bitCnt_d = 6'd31;
                        end else begin
                            shift_d  = {OPC_PP, addr_q, wdata_q};
                            bitCnt_d = 6'd39;
                        end
                        state_d = OP;
                    end else begin
                        // The status read is the opcode followed by 8 zero bits.
                        shift_d  = {OPC_RDSR, 32'h0};
                        bitCnt_d = 6'd15;
                        state_d  = POLL;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        inFrame = (state_d == WREN) || (state_d == OP) || (state_d == POLL);
        csN_d   = !inFrame;
        sck_d   = inFrame && phase_d;
        mosi_d  = inFrame && shift_d[39];
        busy_d  = (state_d != IDLE) && (state_d != FIN);
        done_d  = (state_d == FIN);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign status = status_q;
    assign sck    = sck_q;
    assign cs_n   = csN_q;
    assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_flash_writer.sv
// ----------------------------------------------------------------------------
// tb_spi_flash_writer
//
// Scoreboard bench for spi_flash_writer. The stimulus tasks push the expected
// outcome of each operation. A monitor process does four things:
//   - models the flash,
//   - logs every SPI frame and every inter-frame gap,
//   - checks the pin protocol on every cycle,
//   - pops and compares the expected outcome on each done pulse.
// ----------------------------------------------------------------------------
module tb_spi_flash_writer;

    localparam int CS_GAP    = 4;
    localparam int MAX_POLLS = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_erase = 1'b0;
    logic [23:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  status;
    logic        sck;
    logic        cs_n;
    logic        mosi;
    logic        miso = 1'b1;

    typedef struct {
        logic        expErr;
        logic [7:0]  expStatus;
        logic [39:0] opData;
        int          opBits;
        int          polls;
    } exp_t;

    exp_t        expQ[$];
    logic [39:0] frameData[$];
    int          frameBits[$];
    int          lowLens[$];
    int          gapLens[$];

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          doneCount = 0;
    int          lastDoneCycle = 0;

    int          busyPolls = 0;
    logic [7:0]  busyVal = 8'h01;

    logic        prevCsn = 1'b1;
    logic        prevDone = 1'b0;
    logic        mosiL = 1'b0;
    int          runLen = 0;
    int          curBits = 0;
    logic [39:0] curData = '0;
    int          pollIdx;
    logic [7:0]  statusNow;

    spi_flash_writer #(
        .CS_GAP   (CS_GAP),
        .MAX_POLLS(MAX_POLLS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_erase(cmd_erase),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .status   (status),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso)
    );

    // 100 MHz clock and a cycle counter used for handshake timing checks
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor, flash model and scoreboard checker, all sampled on the falling
    // edge so they never race with the DUT's rising-edge updates
    always @(negedge clk) begin
        if (rst) begin
            frameData.delete();
            frameBits.delete();
            lowLens.delete();
            gapLens.delete();
            prevCsn  = 1'b1;
            prevDone = 1'b0;
            runLen   = 0;
            curBits  = 0;
            curData  = '0;
        end else begin
            if (cs_n) begin
                checkOutput("idle_sck", 64'(sck), 64'd0);
                checkOutput("idle_mosi", 64'(mosi), 64'd0);
            end else if (sck) begin
                checkOutput("mosi_stable_h", 64'(mosi), 64'(mosiL));
            end

            if (prevCsn && !cs_n) begin
                if (frameData.size() > 0) gapLens.push_back(runLen);
                runLen  = 1;
                curBits = 0;
                curData = '0;
            end else if (!prevCsn && cs_n) begin
                lowLens.push_back(runLen);
                frameData.push_back(curData);
                frameBits.push_back(curBits);
                runLen = 1;
            end else begin
                runLen++;
            end
            prevCsn = cs_n;

            if (!cs_n) begin
                if (!sck) begin
                    mosiL = mosi;
                end else begin
                    curData   = {curData[38:0], mosi};
                    pollIdx   = frameData.size() - 2;
                    statusNow = (pollIdx < busyPolls) ? busyVal : 8'h00;
                    miso      = (curBits >= 8 && curBits < 16) ? statusNow[15 - curBits] : 1'b1;
                    curBits++;
                end
            end

            if (done && prevDone) begin
                checks++;
                errors++;
                $display("[TB] FAIL done_width: got 2+ cycles expected 1");
            end

            if (done && !prevDone) begin
                doneCount++;
                lastDoneCycle = cycle;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done pulse expected none");
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("busy_at_done", 64'(busy), 64'd0);
                    checkOutput("err", 64'(err), 64'(e.expErr));
                    checkOutput("status", 64'(status), 64'(e.expStatus));
                    checkOutput("frame_count", 64'(frameData.size()), 64'(e.polls + 2));
                    checkOutput("gap_count", 64'(gapLens.size()), 64'(e.polls + 1));
                    if (frameData.size() == e.polls + 2) begin
                        checkOutput("wren_data", 64'(frameData[0]), 64'h06);
                        checkOutput("wren_bits", 64'(frameBits[0]), 64'd8);
                        checkOutput("wren_len", 64'(lowLens[0]), 64'd16);
                        checkOutput("op_data", 64'(frameData[1]), 64'(e.opData));
                        checkOutput("op_bits", 64'(frameBits[1]), 64'(e.opBits));
                        checkOutput("op_len", 64'(lowLens[1]), 64'(2 * e.opBits));
                        for (int i = 2; i < frameData.size(); i++) begin
                            checkOutput("poll_data", 64'(frameData[i]), 64'h0500);
                            checkOutput("poll_bits", 64'(frameBits[i]), 64'd16);
                            checkOutput("poll_len", 64'(lowLens[i]), 64'd32);
                        end
                    end
                    foreach (gapLens[i]) checkOutput("gap_len", 64'(gapLens[i]), 64'(CS_GAP));
                end
                frameData.delete();
                frameBits.delete();
                lowLens.delete();
                gapLens.delete();
            end
            prevDone = done;
        end
    end

    // Wait, with a cycle budget, until the monitor has seen the target number of done pulses
    task automatic waitDone(input int target);
        int n;
        n = 0;
        while (doneCount < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (doneCount < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got %0d done pulses expected %0d", doneCount, target);
        end
    endtask

    // Issue one request, queue its hand-computed outcome, and wait for completion
    task automatic applyStimulus(input logic erase, input logic [23:0] a, input logic [7:0] d,
                                 input int nBusy, input logic [7:0] bVal,
                                 input int expPolls, input logic expErr, input logic [7:0] expStatus,
                                 input logic [39:0] expOp, input int expOpBits);
        exp_t e;
        int target;
        busyPolls   = nBusy;
        busyVal     = bVal;
        e.expErr    = expErr;
        e.expStatus = expStatus;
        e.opData    = expOp;
        e.opBits    = expOpBits;
        e.polls     = expPolls;
        expQ.push_back(e);
        target = doneCount + 1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_erase = erase;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        @(negedge clk);
        checkOutput("accept_busy", 64'(busy), 64'd1);
        cmd_valid = 1'b0;
        waitDone(target);
    endtask

    // Directed test sequence
    initial begin
        int target;
        int n;
        int doneBefore;
        exp_t e;

        $display("[TB] reset with cmd_valid held high");
        rst       = 1'b1;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_status", 64'(status), 64'd0);
        checkOutput("rst_cs_n", 64'(cs_n), 64'd1);
        checkOutput("rst_sck", 64'(sck), 64'd0);
        checkOutput("rst_mosi", 64'(mosi), 64'd0);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        $display("[TB] page program, WIP clear on first poll");
        applyStimulus(1'b0, 24'h400010, 8'hA5, 0, 8'h01, 1, 1'b0, 8'h00, 40'h02400010A5, 40);

        $display("[TB] sector erase, WIP set for 3 polls");
        applyStimulus(1'b1, 24'h401000, 8'h00, 3, 8'h01, 4, 1'b0, 8'h00, 40'h20401000, 32);

        $display("[TB] erase finishing on the last allowed poll");
        applyStimulus(1'b1, 24'hFFF000, 8'h00, 4, 8'h01, 5, 1'b0, 8'h00, 40'h20FFF000, 32);

        $display("[TB] back-pressure: cmd_valid held across an operation");
        busyPolls   = 0;
        busyVal     = 8'h01;
        e.expErr    = 1'b0;
        e.expStatus = 8'h00;
        e.opData    = 40'h0200010011;
        e.opBits    = 40;
        e.polls     = 1;
        expQ.push_back(e);
        e.opData    = 40'h200ABCDE;
        e.opBits    = 32;
        expQ.push_back(e);
        target = doneCount + 1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_erase = 1'b0;
        addr      = 24'h000100;
        wdata     = 8'h11;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_accept_busy", 64'(busy), 64'd1);
        cmd_erase = 1'b1;
        addr      = 24'h0ABCDE;
        wdata     = 8'h77;
        waitDone(target);
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_reaccept_gap", 64'(cycle - lastDoneCycle), 64'd2);
        cmd_valid = 1'b0;
        waitDone(target + 1);

        $display("[TB] poll timeout with status 0x03");
        applyStimulus(1'b0, 24'h000000, 8'h00, 99, 8'h03, 5, 1'b1, 8'h03, 40'h0200000000, 40);
        repeat (3) @(negedge clk);
        checkOutput("err_held", 64'(err), 64'd1);
        checkOutput("status_held", 64'(status), 64'h03);

        $display("[TB] reset in the middle of an OP frame");
        busyPolls = 0;
        doneBefore = doneCount;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_erase = 1'b0;
        addr      = 24'h123456;
        wdata     = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(!cs_n && frameData.size() == 1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("op_frame_reached", 64'(frameData.size()), 64'd1);
        repeat (28) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_cs_n", 64'(cs_n), 64'd1);
        checkOutput("abort_sck", 64'(sck), 64'd0);
        checkOutput("abort_mosi", 64'(mosi), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_status", 64'(status), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("no_done_after_abort", 64'(doneCount), 64'(doneBefore));

        $display("[TB] program after abort, top address and all-ones data");
        applyStimulus(1'b0, 24'h7FFFFF, 8'hFF, 0, 8'h01, 1, 1'b0, 8'h00, 40'h027FFFFFFF, 40);

        repeat (5) @(negedge clk);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_writer.md
SPI_FLASH_WRITER -- requirements
Module: spi_flash_writer

Interface
REQ-001 SHALL have parameter CS_GAP, default 4: clk cycles that cs_n is held high between frames (minimum 2).
REQ-002 SHALL have parameter MAX_POLLS, default 1_000_000: number of status reads before timeout.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid, input, 1: request strobe, sampled only while busy=0.
REQ-006 SHALL have port cmd_erase, input, 1: 1 = 4 KB sector erase (0x20); 0 = single-byte page program (0x02).
REQ-007 SHALL have port addr, input, 24: flash byte address.
REQ-008 SHALL have port wdata, input, 8: byte to program; ignored for erase.
REQ-009 SHALL have port busy, output, 1: operation in progress.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1: timeout flag for the last operation, valid while done=1 and held until the next acceptance.
REQ-012 SHALL have port status, output, 8: last status register byte read.
REQ-013 SHALL have ports sck (output, 1), cs_n (output, 1), mosi (output, 1) and miso (input, 1): SPI mode 0 to the flash.

Function
REQ-014 SHALL accept a request on a clk edge where cmd_valid=1 and busy=0, latching cmd_erase, addr and wdata; busy SHALL read 1 from the next cycle.
REQ-015 SHALL ignore cmd_valid while busy=1, with no queuing.
REQ-016 SHALL have states IDLE, WREN, GAP1, OP, GAP2, POLL, GAP3 and FIN.
REQ-017 SHALL transfer each SPI bit in 2 clk cycles:
- phase L: sck=0, mosi = current bit, MSB first.
- phase H: sck=1.
- miso SHALL be sampled on the edge that ends phase H.
REQ-018 SHALL drive cs_n=0 only during frames; it falls on the same edge that presents the first bit in phase L, and rises on the edge after the last phase H.
REQ-019 SHALL send 0x06 in WREN, then hold cs_n high for CS_GAP cycles in GAP1.
REQ-020 SHALL send 0x02, addr[23:0], wdata in OP when cmd_erase=0: 40 bits, 80 cycles.
REQ-021 SHALL send 0x20, addr[23:0] in OP when cmd_erase=1: 32 bits, 64 cycles.
REQ-022 SHALL hold cs_n high for CS_GAP cycles in GAP2.
REQ-023 SHALL send 0x05 in POLL, then clock 8 further bits with mosi=0 while shifting miso into status (16 bits, 32 cycles).
REQ-024 SHALL go to GAP3 (CS_GAP cycles), then back to POLL, when status[0] (WIP) = 1 at the end of POLL.
REQ-025 SHALL go to FIN with err=0 when WIP=0.
REQ-026 SHALL count polls in a counter of at least 20 bits, cleared on acceptance; when WIP=1 after the MAX_POLLS-th poll, it SHALL go to FIN with err=1.
REQ-027 SHALL, in FIN, pulse done=1 for exactly one cycle and drop busy in the same cycle; a new request is accepted from the following cycle.
REQ-028 SHALL hold sck=0 and mosi=0 whenever cs_n=1.
REQ-029 SHALL update status only at the end of a POLL frame.

Reset
REQ-030 SHALL, while rst=1, force on the next edge: state IDLE, cs_n=1, sck=0, mosi=0, busy=0, done=0, err=0, status=0x00, all counters 0.
REQ-031 SHALL, on rst during any frame, abort that frame with cs_n high on the next edge; no done pulse is produced for the aborted request.
REQ-032 SHALL give rst priority over a cmd_valid in the same cycle.

Verification
REQ-033 Program: cmd_erase=0, addr=0x400010, wdata=0xA5, flash model returns WIP=0 on the first poll -> mosi bytes 06 | 02 40 00 10 A5 | 05; cs_n low for 16, 80 and 32 cycles with gaps of 4; done after 1 poll; err=0; status=0x00.
REQ-034 Erase: cmd_erase=1, addr=0x401000, model returns WIP=1 for 3 polls then 0 -> bytes 06 | 20 40 10 00 | 05×4; one done pulse; status=0x00; err=0.
REQ-035 Timeout: MAX_POLLS=5, model always returns 0x03 -> exactly 5 POLL frames; done with err=1; status=0x03.
REQ-036 Back-pressure: cmd_valid held high for the whole of one operation -> second request accepted only on the cycle after done; the two operations do not overlap.
REQ-037 Reset mid-OP: rst asserted at cycle 30 of an OP frame -> cs_n=1, sck=0, busy=0 on the next edge; no done pulse; a new request afterwards completes normally.
REQ-038 Protocol checker on every run: sck toggles only while cs_n=0; mosi is stable throughout each phase H; sck idles at 0.
